dec3to8_stream: RTL and testbench
=================================

// Module: dec3to8_stream
// PURPOSE
// - Streaming binary-to-one-hot decoder; inverse of the team's one-hot-to-binary encoder.
// - Accepts an IN_W-bit code over a valid/ready handshake.
// - Returns the OUT_W-bit one-hot word over a valid/ready handshake, with 1-cycle latency.
// - Internal 2-entry skid buffer sustains 1 word/cycle under backpressure.
// - Sits between a code producer (e.g. an arbiter or encoder output) and one-hot select consumers.
// PARAMETERS
// IN_W   3             code width
// OUT_W  1<<IN_W (8)   one-hot output width; must equal 2**IN_W
// CNT_W  8             width of the decode counter
// PORTS
// clk         in   1      clock; all logic on rising edge
// rst         in   1      synchronous reset, active-high
// in_valid    in   1      in_code/in_en valid
// in_ready    out  1      block can accept this cycle
// in_code     in   IN_W   binary code to decode
// in_en       in   1      decode enable; 0 -> all-zero output word for this transfer
// out_valid   out  1      out_onehot valid
// out_ready   in   1      consumer accepts this cycle
// out_onehot  out  OUT_W  decoded word
// dec_count   out  CNT_W  number of accepted transfers with in_en=1
// BEHAVIOUR
// - Clock and reset: one clock clk; reset rst is synchronous and active-high.
// - Reset values: state=EMPTY, out_valid=0, out_onehot=0, dec_count=0, skid contents cleared.
// - in_ready is 0 while rst=1.
// - Transfer rules: accept = in_valid&in_ready; pop = out_valid&out_ready.
// - in_valid may not depend on in_ready. out_ready may toggle freely.
// - Decode function: word = in_en ? (1<<in_code) : 0.
//   - Computed at accept time and stored; out_onehot is registered, never combinational from in_code.
// - Latency: word accepted at edge N appears with out_valid=1 after edge N (visible in cycle N+1).
// - Occupancy FSM (main reg M, skid reg S):
//   - EMPTY: in_ready=1, out_valid=0, out_onehot=0.
//     - accept -> load M, go ONE.
//   - ONE: in_ready=1, out_valid=1, out_onehot=M.
//     - accept&pop -> reload M, stay ONE.
//     - accept&!pop -> load S, go TWO.
//     - pop&!accept -> go EMPTY.
//   - TWO: in_ready=0, out_valid=1, out_onehot=M.
//     - pop -> M<=S, go ONE.
//     - else hold.
// - in_ready is decoded from state only (state!=TWO && !rst): no combinational path from out_ready.
// - Ordering: strictly FIFO; no word dropped or duplicated.
// - out_onehot is stable while out_valid=1 and out_ready=0.
// - dec_count: +1 on each accept with in_en=1.
//   - Increments at the accept edge, not at pop.
//   - Wraps 2**CNT_W-1 -> 0 silently.
// - Reset mid-operation: buffered words are discarded.
//   - out_valid falls the cycle after the rst edge; dec_count clears.
// - No X propagation: in_code is ignored (not stored) when accept=0.
// TESTING
// T1 reset: hold rst 3 cycles with in_valid=1
//    -> in_ready=0, out_valid=0, out_onehot=8'h00, dec_count=0.
// T2 sweep: codes 0..7, en=1, out_ready=1
//    -> out_onehot 01,02,04,...,80, each 1 cycle after accept; dec_count=8.
// T3 enable: code=5 en=0, then code=5 en=1
//    -> outputs 8'h00 then 8'h20; dec_count +1 only.
// T4 backpressure: send 3,6,1 back-to-back with out_ready=0
//    -> in_ready drops after 2nd accept, 3rd held.
//    -> release out_ready: outputs 08,40,02 in order, out_onehot stable while stalled.
// T5 full throughput: random codes every cycle, out_ready=1
//    -> in_ready stays 1, one output per cycle, scoreboard matches.
// T6 reset mid-stream: rst while in TWO
//    -> next cycle out_valid=0, dec_count=0, no stale word emitted after reset.
//    -> wrap: 256 en=1 accepts -> dec_count=0.

Source files
------------

// File: rtl/dec3to8_stream.sv
// Streaming binary-to-one-hot decoder with a two-entry skid buffer.
// The word is decoded at accept time and registered, so out_onehot never depends combinationally on in_code.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_EMPTY | nothing buffered, out_valid=0, out_onehot=0
// ST_ONE   | main register holds the word being presented
// ST_TWO   | main presented, skid holds the next word, stall input
module dec3to8_stream #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 1 << IN_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic [CNT_W-1:0] dec_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   main_q, skid_q;
  logic [CNT_W-1:0]   dec_count_q;
  logic [OUT_W-1:0]   word_in;
  logic               accept, pop;
  logic               load_main, load_skid, main_from_skid;

  // in_ready comes from state and reset only, keeping out_ready off the input path
  assign in_ready  = (state_q != ST_TWO) && !rst;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_onehot = out_valid ? main_q : '0;
  assign dec_count = dec_count_q;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  assign word_in = in_en ? (OUT_W'(1) << in_code) : '0;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          main_from_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      dec_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) begin
        main_q <= word_in;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= word_in;
      end else if (main_from_skid) begin
        skid_q <= '0;
      end
      // counts at the accept edge; wraps silently
      if (accept && in_en) begin
        dec_count_q <= dec_count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dec3to8_stream.sv
// Randomized scoreboard bench for dec3to8_stream: the driver side pushes expected words on accept,
// an independent monitor pops and compares whenever the decoder hands a word over.
module tb_dec3to8_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_code = 3'd0;
  logic       in_en = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_onehot;
  logic [7:0] dec_count;

  typedef struct {
    logic [7:0]  word;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int          model_count = 0;
  bit          chk_lat = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_word = 8'h00;

  dec3to8_stream dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_en      (in_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .dec_count  (dec_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: one-hot is the power of two selected by the code, or nothing when disabled
  function automatic logic [7:0] ref_word(input int code, input bit en);
    int v;
    v = en ? (2 ** code) : 0;
    return v[7:0];
  endfunction

  // Accept observer: the handshake seen mid-cycle is what the next rising edge commits
  always @(negedge clk) begin
    exp_t e;
    if (!rst && in_valid && in_ready) begin
      e.word = ref_word(int'(in_code), in_en);
      e.cyc  = cyc;
      sb.push_back(e);
      if (in_en) model_count = (model_count + 1) % 256;
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_stable", {24'd0, out_onehot}, {24'd0, prev_word});
      end
      if (out_valid === 1'b0) check("idle_zero", {24'd0, out_onehot}, 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", out_onehot, cyc);
        end else begin
          e = sb.pop_front();
          check("data", {24'd0, out_onehot}, {24'd0, e.word});
          if (chk_lat) check("latency", cyc - e.cyc, 32'd1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = out_onehot;
    end
  end

  task automatic send(input logic [2:0] code, input logic en, output int stalls);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_code  = code;
    in_en    = en;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    stalls = n;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || in_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int stall_sum;
    logic [2:0] c;

    // T1 reset with in_valid asserted
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("t1_in_ready", {31'd0, in_ready}, 32'd0);
    check("t1_out_valid", {31'd0, out_valid}, 32'd0);
    check("t1_onehot", {24'd0, out_onehot}, 32'd0);
    check("t1_count", {24'd0, dec_count}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;

    // T2 sweep
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) send(3'(i), 1'b1, st);
    drain();
    check("t2_count", {24'd0, dec_count}, 32'd8);
    check("t2_model", {24'd0, dec_count}, model_count);

    // T3 enable
    send(3'd5, 1'b0, st);
    send(3'd5, 1'b1, st);
    drain();
    check("t3_count", {24'd0, dec_count}, 32'd9);
    chk_lat = 1'b0;

    // T4 backpressure
    out_ready = 1'b0;
    fork
      begin
        send(3'd3, 1'b1, st);
        send(3'd6, 1'b1, st);
        send(3'd1, 1'b1, st);
      end
    join_none
    repeat (5) @(negedge clk);
    check("t4_in_ready", {31'd0, in_ready}, 32'd0);
    check("t4_held", {31'd0, in_valid}, 32'd1);
    check("t4_head", {24'd0, out_onehot}, 32'h08);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    check("t4_count", {24'd0, dec_count}, 32'd12);

    // T5 full throughput
    chk_lat = 1'b1;
    stall_sum = 0;
    for (int i = 0; i < 200; i++) begin
      c = 3'($urandom_range(0, 7));
      send(c, 1'($urandom_range(0, 1)), st);
      stall_sum += st;
    end
    drain();
    chk_lat = 1'b0;
    check("t5_no_stall", stall_sum, 32'd0);
    check("t5_count", {24'd0, dec_count}, model_count);

    // Random backpressure mix
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 100; i++) begin
      c = 3'($urandom_range(0, 7));
      send(c, 1'($urandom_range(0, 3) != 0), st);
    end
    repeat (160) @(posedge clk);
    #1;
    drain();
    check("mix_count", {24'd0, dec_count}, model_count);

    // T6 reset while two words are buffered
    out_ready = 1'b0;
    send(3'd2, 1'b1, st);
    send(3'd7, 1'b1, st);
    @(negedge clk);
    check("t6_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    model_count = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_count", {24'd0, dec_count}, 32'd0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Counter wrap
    for (int i = 0; i < 256; i++) begin
      c = 3'($urandom_range(0, 7));
      send(c, 1'b1, st);
    end
    drain();
    check("wrap_count", {24'd0, dec_count}, 32'd0);
    check("wrap_model", {24'd0, dec_count}, model_count);
    send(3'd4, 1'b1, st);
    drain();
    check("wrap_plus1", {24'd0, dec_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
